// File: rtl/spn_iter_core.sv
// spn_iter_core: iterative SPN block cipher core, one round per clock.
//
// Block width W = 4*NIBBLES bits, ROUNDS rounds. The round key is derived on
// the fly by rotating a single key register 4 bits per round: left while
// encrypting (K_0 -> K_ROUNDS), right while decrypting (the register is loaded
// with K_ROUNDS at accept and walks back down to K_0).
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   request handshake; in_ready low while flush is high
//   in_mode             0 = encrypt, 1 = decrypt
//   in_data, in_key     W-bit block and master key
//   flush               synchronous abort of the current operation
//   out_valid/out_ready result handshake
//   out_data            W-bit result, held stable while out_valid is high
//   busy                high while running or holding a result
//
// Build option: define SPN_KEY_ZEROIZE_EN to clear the key, data and result
// registers on every return to IDLE.

module spn_iter_core #(
  parameter int NIBBLES = 4,
  parameter int ROUNDS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic [4*NIBBLES-1:0]   in_key,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   busy
);

  localparam int W   = 4 * NIBBLES;
  localparam int CW  = (ROUNDS < 2) ? 1 : $clog2(ROUNDS + 1);
  // Rotation (in bits) that turns the master key into K_ROUNDS.
  localparam int KSH = 4 * (ROUNDS % NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] v);
    case (v)
      4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
      4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
      4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
      4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] v);
    case (v)
      4'h0: inv_sbox4 = 4'h5;  4'h1: inv_sbox4 = 4'hE;  4'h2: inv_sbox4 = 4'hF;  4'h3: inv_sbox4 = 4'h8;
      4'h4: inv_sbox4 = 4'hC;  4'h5: inv_sbox4 = 4'h1;  4'h6: inv_sbox4 = 4'h2;  4'h7: inv_sbox4 = 4'hD;
      4'h8: inv_sbox4 = 4'hB;  4'h9: inv_sbox4 = 4'h4;  4'hA: inv_sbox4 = 4'h6;  4'hB: inv_sbox4 = 4'h3;
      4'hC: inv_sbox4 = 4'h0;  4'hD: inv_sbox4 = 4'h7;  4'hE: inv_sbox4 = 4'h9;  default: inv_sbox4 = 4'hA;
    endcase
  endfunction

  function automatic logic [W-1:0] sub_layer(input logic [W-1:0] v, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      r[4*i +: 4] = inv ? inv_sbox4(v[4*i +: 4]) : sbox4(v[4*i +: 4]);
    end
    return r;
  endfunction

  // Half-width rotation; applying it twice is the identity.
  function automatic logic [W-1:0] pbox(input logic [W-1:0] v);
    return {v[W/2-1:0], v[W-1:W/2]};
  endfunction

  function automatic logic [W-1:0] rotl4(input logic [W-1:0] v);
    return {v[W-5:0], v[W-1:W-4]};
  endfunction

  function automatic logic [W-1:0] rotr4(input logic [W-1:0] v);
    return {v[3:0], v[W-1:4]};
  endfunction

  // Rotate left by s bits, 0 <= s < W.
  function automatic logic [W-1:0] rotl_bits(input logic [W-1:0] v, input int s);
    logic [2*W-1:0] dbl;
    dbl = {v, v} >> (W - s);
    return dbl[W-1:0];
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    key_q, key_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    enc_out, dec_in, dec_out, round_out, key_nxt;

  // Round datapath for the current counter value.
  always_comb begin
    enc_out = pbox(sub_layer(x_q ^ key_q, 1'b0));
    if (cnt_q == LAST) enc_out = enc_out ^ rotl4(key_q);
    // key_q holds K_ROUNDS on the first decrypt step: undo output whitening.
    dec_in    = (cnt_q == '0) ? (x_q ^ key_q) : x_q;
    dec_out   = sub_layer(pbox(dec_in), 1'b1) ^ rotr4(key_q);
    round_out = mode_q ? dec_out : enc_out;
    key_nxt   = mode_q ? rotr4(key_q) : rotl4(key_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    key_d      = key_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_d = S_RUN;
          x_d     = in_data;
          key_d   = in_mode ? rotl_bits(in_key, KSH) : in_key;
          mode_d  = in_mode;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          x_d   = round_out;
          key_d = key_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d    = S_DONE;
            out_data_d = round_out;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SPN_KEY_ZEROIZE_EN
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      key_d      = '0;
      x_d        = '0;
      out_data_d = '0;
    end
`endif
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Flush wins over a same-cycle request, so the ready must drop with it.
  assign in_ready  = in_ready_q && !flush;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
